add_compare_select_unit: RTL and testbench

Path-metric stage of the 4-state (K=3, rate-1/2, generators 7/5 octal) hard-decision Viterbi decoder. It sits directly upstream of `Survivor_path_memory_unit`. For each received 2-bit code symbol it computes Hamming branch metrics and runs add-compare-select over the trellis. It outputs normalized, saturated path metrics `o_PM_0..3` plus per-state survivor decision bits.

---
 rtl/viterbi_pkg.sv | 42 ++++
 rtl/acs_butterfly.sv | 36 +++
 rtl/add_compare_select_unit.sv | 138 +++++++++++++
 tb/tb_add_compare_select_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | viterbi_pkg : trellis constants and helpers for the K=3 7/5 decoder |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package viterbi_pkg;

  // State encoding {s1,s0} = {b[n-1], b[n-2]}
  localparam logic [1:0] c_s0 = 2'd0;
  localparam logic [1:0] c_s1 = 2'd1;
  localparam logic [1:0] c_s2 = 2'd2;
  localparam logic [1:0] c_s3 = 2'd3;

  // Expected code symbol {g0,g1} on each trellis edge
  localparam logic [1:0] c_exp_s0_s0 = 2'b00;
  localparam logic [1:0] c_exp_s0_s2 = 2'b11;
  localparam logic [1:0] c_exp_s1_s0 = 2'b11;
  localparam logic [1:0] c_exp_s1_s2 = 2'b00;
  localparam logic [1:0] c_exp_s2_s1 = 2'b10;
  localparam logic [1:0] c_exp_s2_s3 = 2'b01;
  localparam logic [1:0] c_exp_s3_s1 = 2'b01;
  localparam logic [1:0] c_exp_s3_s3 = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acs_state_e;

  function automatic int unsigned pm_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Hamming distance between received and expected symbol
  function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                               input logic [1:0] expd);
    logic [1:0] x;
    x = sym ^ expd;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/acs_butterfly.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | acs_butterfly : two add-compare units sharing one branch-metric pair|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module acs_butterfly #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_pm_even,
  input  logic [W-1:0] i_pm_odd,
  input  logic [1:0]   i_bm_x,
  input  logic [1:0]   i_bm_y,
  output logic [W-1:0] o_cand_p,
  output logic [W-1:0] o_cand_q,
  output logic         o_dec_p,
  output logic         o_dec_q
);

  logic [W-1:0] w_even_x;
  logic [W-1:0] w_even_y;
  logic [W-1:0] w_odd_x;
  logic [W-1:0] w_odd_y;

  assign w_even_x = i_pm_even + W'(i_bm_x);
  assign w_even_y = i_pm_even + W'(i_bm_y);
  assign w_odd_x  = i_pm_odd  + W'(i_bm_x);
  assign w_odd_y  = i_pm_odd  + W'(i_bm_y);

  // Ties keep the even predecessor (decision bit 0)
  assign o_dec_p  = (w_odd_y < w_even_x);
  assign o_dec_q  = (w_odd_x < w_even_y);
  assign o_cand_p = o_dec_p ? w_odd_y : w_even_x;
  assign o_cand_q = o_dec_q ? w_odd_x : w_even_y;

endmodule
`default_nettype wire

// File: rtl/add_compare_select_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | add_compare_select_unit : 4-state ACS with normalized, saturated PMs|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module add_compare_select_unit #(
  parameter int PM_W = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_valid,
  input  logic [1:0]      i_symbol,
  output logic            o_valid,
  output logic [PM_W-1:0] o_PM_0,
  output logic [PM_W-1:0] o_PM_1,
  output logic [PM_W-1:0] o_PM_2,
  output logic [PM_W-1:0] o_PM_3,
  output logic [3:0]      o_dec,
  output logic            o_settled
);

  import viterbi_pkg::*;

  localparam int              CW       = PM_W + 2;
  localparam logic [PM_W-1:0] c_pm_max = PM_W'(pm_max(PM_W));

  acs_state_e      r_state;
  logic [PM_W-1:0] r_pm [4];
  logic [3:0]      r_dec;
  logic            r_valid;
  logic [1:0]      r_settle_cnt;

  logic [PM_W-1:0] w_src [4];
  logic [CW-1:0]   w_cand [4];
  logic [CW-1:0]   w_diff [4];
  logic [PM_W-1:0] w_norm [4];
  logic [3:0]      w_dec;
  logic [CW-1:0]   w_min_lo;
  logic [CW-1:0]   w_min_hi;
  logic [CW-1:0]   w_min;
  logic [1:0]      w_bm00;
  logic [1:0]      w_bm11;
  logic [1:0]      w_bm10;
  logic [1:0]      w_bm01;

  // The first symbol of a frame always starts from the init vector
  always_comb begin
    if (r_state == IDLE) begin
      w_src[c_s0] = '0;
      w_src[c_s1] = c_pm_max;
      w_src[c_s2] = c_pm_max;
      w_src[c_s3] = c_pm_max;
    end else begin
      w_src = r_pm;
    end
  end

  assign w_bm00 = branch_metric(i_symbol, c_exp_s0_s0);
  assign w_bm11 = branch_metric(i_symbol, c_exp_s0_s2);
  assign w_bm10 = branch_metric(i_symbol, c_exp_s2_s1);
  assign w_bm01 = branch_metric(i_symbol, c_exp_s2_s3);

  acs_butterfly #(.W(CW)) u_bfly_01 (
    .i_pm_even ({2'b00, w_src[c_s0]}),
    .i_pm_odd  ({2'b00, w_src[c_s1]}),
    .i_bm_x    (w_bm00),
    .i_bm_y    (w_bm11),
    .o_cand_p  (w_cand[c_s0]),
    .o_cand_q  (w_cand[c_s2]),
    .o_dec_p   (w_dec[c_s0]),
    .o_dec_q   (w_dec[c_s2])
  );

  acs_butterfly #(.W(CW)) u_bfly_23 (
    .i_pm_even ({2'b00, w_src[c_s2]}),
    .i_pm_odd  ({2'b00, w_src[c_s3]}),
    .i_bm_x    (w_bm10),
    .i_bm_y    (w_bm01),
    .o_cand_p  (w_cand[c_s1]),
    .o_cand_q  (w_cand[c_s3]),
    .o_dec_p   (w_dec[c_s1]),
    .o_dec_q   (w_dec[c_s3])
  );

  assign w_min_lo = (w_cand[1] < w_cand[0]) ? w_cand[1] : w_cand[0];
  assign w_min_hi = (w_cand[3] < w_cand[2]) ? w_cand[3] : w_cand[2];
  assign w_min    = (w_min_hi < w_min_lo) ? w_min_hi : w_min_lo;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_diff[i] = w_cand[i] - w_min;
      w_norm[i] = (w_diff[i] > CW'(c_pm_max)) ? c_pm_max : w_diff[i][PM_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_pm[c_s0]   <= '0;
      r_pm[c_s1]   <= c_pm_max;
      r_pm[c_s2]   <= c_pm_max;
      r_pm[c_s3]   <= c_pm_max;
      r_dec        <= '0;
      r_valid      <= 1'b0;
      r_settle_cnt <= 2'd0;
    end else if (i_start) begin
      r_state      <= IDLE;
      r_pm[c_s0]   <= '0;
      r_pm[c_s1]   <= c_pm_max;
      r_pm[c_s2]   <= c_pm_max;
      r_pm[c_s3]   <= c_pm_max;
      r_dec        <= '0;
      r_valid      <= 1'b0;
      r_settle_cnt <= 2'd0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_state <= RUN;
        r_pm    <= w_norm;
        r_dec   <= w_dec;
        if (r_settle_cnt != 2'd3) begin
          r_settle_cnt <= r_settle_cnt + 2'd1;
        end
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_PM_0    = r_pm[c_s0];
  assign o_PM_1    = r_pm[c_s1];
  assign o_PM_2    = r_pm[c_s2];
  assign o_PM_3    = r_pm[c_s3];
  assign o_dec     = r_dec;
  assign o_settled = r_settle_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_add_compare_select_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_add_compare_select_unit : directed vectors, PM_W=2              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_add_compare_select_unit;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic       i_valid;
  logic [1:0] i_symbol;
  logic       o_valid;
  logic [1:0] o_PM_0;
  logic [1:0] o_PM_1;
  logic [1:0] o_PM_2;
  logic [1:0] o_PM_3;
  logic [3:0] o_dec;
  logic       o_settled;

  int n_checks;
  int n_errors;

  add_compare_select_unit #(.PM_W(2)) u_dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_valid   (i_valid),
    .i_symbol  (i_symbol),
    .o_valid   (o_valid),
    .o_PM_0    (o_PM_0),
    .o_PM_1    (o_PM_1),
    .o_PM_2    (o_PM_2),
    .o_PM_3    (o_PM_3),
    .o_dec     (o_dec),
    .o_settled (o_settled)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected metrics packed as {PM0,PM1,PM2,PM3}
  task automatic check_pm(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, o_PM_0, o_PM_1, o_PM_2, o_PM_3}, {24'd0, exp});
  endtask

  task automatic step(input logic v, input logic s, input logic [1:0] sym);
    i_valid  = v;
    i_start  = s;
    i_symbol = sym;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_start  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    i_clk    = 1'b0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_valid  = 1'b0;
    i_symbol = 2'b00;
    repeat (2) @(posedge i_clk);
    #1;
    check_pm("reset_pm", {2'd0, 2'd3, 2'd3, 2'd3});
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_dec", {28'd0, o_dec}, 32'd0);
    check("reset_settled", {31'd0, o_settled}, 32'd0);
    i_rst = 1'b0;

    step(1'b1, 1'b0, 2'b00);
    check_pm("init_sym00_pm", {2'd0, 2'd3, 2'd2, 2'd3});
    check("init_sym00_dec", {28'd0, o_dec}, 32'd0);
    check("init_sym00_valid", {31'd0, o_valid}, 32'd1);
    step(1'b0, 1'b1, 2'b00);
    check_pm("restart_a_pm", {2'd0, 2'd3, 2'd3, 2'd3});

    step(1'b1, 1'b0, 2'b11);
    check_pm("init_sym11_pm", {2'd2, 2'd3, 2'd0, 2'd3});
    check("init_sym11_dec", {28'd0, o_dec}, 32'd0);
    step(1'b0, 1'b1, 2'b00);

    // Clean stream for inputs 1,0,1,1
    step(1'b1, 1'b0, 2'b11);
    check_pm("stream1_pm", {2'd2, 2'd3, 2'd0, 2'd3});
    check("stream1_settled", {31'd0, o_settled}, 32'd0);
    step(1'b1, 1'b0, 2'b10);
    check_pm("stream2_pm", {2'd3, 2'd0, 2'd3, 2'd2});
    check("stream2_dec", {28'd0, o_dec}, 32'd0);
    check("stream2_settled", {31'd0, o_settled}, 32'd1);
    step(1'b1, 1'b0, 2'b00);
    check_pm("stream3_pm", {2'd2, 2'd3, 2'd0, 2'd3});
    check("stream3_dec", {28'd0, o_dec}, 32'hF);

    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 2'b11);
      check_pm("hold_pm", {2'd2, 2'd3, 2'd0, 2'd3});
      check("hold_dec", {28'd0, o_dec}, 32'hF);
      check("hold_valid", {31'd0, o_valid}, 32'd0);
    end

    step(1'b1, 1'b0, 2'b01);
    check_pm("stream4_pm", {2'd3, 2'd2, 2'd3, 2'd0});
    check("stream4_dec", {28'd0, o_dec}, 32'd0);
    check("stream4_valid", {31'd0, o_valid}, 32'd1);
    check("stream4_settled", {31'd0, o_settled}, 32'd1);

    step(1'b1, 1'b1, 2'b11);
    check_pm("start_drop_pm", {2'd0, 2'd3, 2'd3, 2'd3});
    check("start_drop_valid", {31'd0, o_valid}, 32'd0);
    check("start_drop_settled", {31'd0, o_settled}, 32'd0);

    // Asynchronous reset asserted between clock edges
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b11);
    check_pm("pre_areset_pm", {2'd2, 2'd3, 2'd0, 2'd3});
    check("pre_areset_settled", {31'd0, o_settled}, 32'd1);
    #3;
    i_rst = 1'b1;
    #1;
    check_pm("areset_pm", {2'd0, 2'd3, 2'd3, 2'd3});
    check("areset_valid", {31'd0, o_valid}, 32'd0);
    check("areset_settled", {31'd0, o_settled}, 32'd0);
    check("areset_dec", {28'd0, o_dec}, 32'd0);
    #2;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    step(1'b1, 1'b0, 2'b00);
    check_pm("post_areset_pm", {2'd0, 2'd3, 2'd2, 2'd3});
    check("post_areset_valid", {31'd0, o_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
